// File: rtl/noise_reg_if.sv
// noise_reg_if: noise-channel register block (NR41..NR44) with a stretchable trigger strobe.
// Readback path is compiled in only when NOISE_REG_READBACK_EN is defined; otherwise rd_data=8'hFF.
module noise_reg_if #(
   parameter int unsigned TRIG_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_on,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [1:0] addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic [5:0] length,
   output logic [3:0] start_vol,
   output logic       env_dir,
   output logic [2:0] env_period,
   output logic [3:0] clock_shift,
   output logic       width_mode,
   output logic [2:0] divisor,
   output logic       length_en,
   output logic       length_load,
   output logic       trigger
);

   typedef enum logic {IDLE, FIRE} trigState_e;

   localparam logic [3:0] TrigLoad = 4'(TRIG_CYCLES - 1);

   logic       wrAccept, nr41Wr, nr42Wr, nr43Wr, nr44Wr, trigReq;

   logic [5:0] length_q, length_d;
   logic [3:0] startVol_q, startVol_d;
   logic       envDir_q, envDir_d;
   logic [2:0] envPeriod_q, envPeriod_d;
   logic [3:0] clockShift_q, clockShift_d;
   logic       widthMode_q, widthMode_d;
   logic [2:0] divisor_q, divisor_d;
   logic       lengthEn_q, lengthEn_d;
   logic       lengthLoad_q, lengthLoad_d;

   trigState_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   assign wrAccept = wr_en & power_on;
   assign nr41Wr   = wrAccept && (addr == 2'd0);
   assign nr42Wr   = wrAccept && (addr == 2'd1);
   assign nr43Wr   = wrAccept && (addr == 2'd2);
   assign nr44Wr   = wrAccept && (addr == 2'd3);
   assign trigReq  = nr44Wr & wr_data[7];

   // Powering down wipes the whole register file; NR44 bit7 is a command and never stored.
   always_comb begin
      length_d     = length_q;
      startVol_d   = startVol_q;
      envDir_d     = envDir_q;
      envPeriod_d  = envPeriod_q;
      clockShift_d = clockShift_q;
      widthMode_d  = widthMode_q;
      divisor_d    = divisor_q;
      lengthEn_d   = lengthEn_q;
      lengthLoad_d = 1'b0;
      if (!power_on) begin
         length_d     = '0;
         startVol_d   = '0;
         envDir_d     = 1'b0;
         envPeriod_d  = '0;
         clockShift_d = '0;
         widthMode_d  = 1'b0;
         divisor_d    = '0;
         lengthEn_d   = 1'b0;
      end else begin
         if (nr41Wr) begin
            length_d     = wr_data[5:0];
            lengthLoad_d = 1'b1;
         end
         if (nr42Wr) begin
            startVol_d  = wr_data[7:4];
            envDir_d    = wr_data[3];
            envPeriod_d = wr_data[2:0];
         end
         if (nr43Wr) begin
            clockShift_d = wr_data[7:4];
            widthMode_d  = wr_data[3];
            divisor_d    = wr_data[2:0];
         end
         if (nr44Wr) begin
            lengthEn_d = wr_data[6];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         length_q     <= '0;
         startVol_q   <= '0;
         envDir_q     <= 1'b0;
         envPeriod_q  <= '0;
         clockShift_q <= '0;
         widthMode_q  <= 1'b0;
         divisor_q    <= '0;
         lengthEn_q   <= 1'b0;
         lengthLoad_q <= 1'b0;
      end else begin
         length_q     <= length_d;
         startVol_q   <= startVol_d;
         envDir_q     <= envDir_d;
         envPeriod_q  <= envPeriod_d;
         clockShift_q <= clockShift_d;
         widthMode_q  <= widthMode_d;
         divisor_q    <= divisor_d;
         lengthEn_q   <= lengthEn_d;
         lengthLoad_q <= lengthLoad_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A retrigger while firing reloads the counter so the strobe stretches with no low gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (trigReq) begin
               state_d = FIRE;
               cnt_d   = TrigLoad;
            end
         end
         FIRE: begin
            if (trigReq) begin
               cnt_d = TrigLoad;
            end else if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!power_on) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      trigger = (state_q == FIRE);
   end

   assign length      = length_q;
   assign start_vol   = startVol_q;
   assign env_dir     = envDir_q;
   assign env_period  = envPeriod_q;
   assign clock_shift = clockShift_q;
   assign width_mode  = widthMode_q;
   assign divisor     = divisor_q;
   assign length_en   = lengthEn_q;
   assign length_load = lengthLoad_q;

`ifdef NOISE_REG_READBACK_EN
   logic [7:0] rdMux;
   logic [7:0] rdData_q, rdData_d;
   logic       rdValid_q;

   // Samples register state before this edge's write lands, so read-during-write sees old data.
   always_comb begin
      case (addr)
         2'd0:    rdMux = 8'hFF;
         2'd1:    rdMux = {startVol_q, envDir_q, envPeriod_q};
         2'd2:    rdMux = {clockShift_q, widthMode_q, divisor_q};
         default: rdMux = {1'b1, lengthEn_q, 6'h3F};
      endcase
      rdData_d = rd_en ? rdMux : rdData_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         rdData_q  <= rdData_d;
         rdValid_q <= rd_en;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
`else
   logic unusedReadEnable;

   assign unusedReadEnable = rd_en;
   assign rd_data          = 8'hFF;
   assign rd_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_noise_reg_if.sv
// tb_noise_reg_if: table-driven scoreboard bench for noise_reg_if, plus trigger/power/reset sequences.
// Readback expectations follow NOISE_REG_READBACK_EN as defined for the build.
module tb_noise_reg_if;

   localparam int TrigCycles = 4;

   logic       clk = 1'b0;
   logic       reset, power_on, wr_en, rd_en;
   logic [1:0] addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [5:0] length;
   logic [3:0] start_vol;
   logic       env_dir;
   logic [2:0] env_period;
   logic [3:0] clock_shift;
   logic       width_mode;
   logic [2:0] divisor;
   logic       length_en;
   logic       length_load;
   logic       trigger;

   int errors = 0;
   int checks = 0;
   int hiCount;
   logic rdValidSeen = 1'b0;

   typedef struct {
      logic        power;
      logic        wr;
      logic [1:0]  addr;
      logic [7:0]  data;
      logic [22:0] cfg;
      logic        ll;
      logic        trig;
   } vec_t;

   typedef struct {
      logic [22:0] cfg;
      logic        ll;
      logic        trig;
   } expRec_t;

   vec_t    vecs[10];
   expRec_t sbQ[$];
   logic [8:0] rdQ[$];
   expRec_t expRec;
   logic [8:0] rdExp;

   always #5 clk = ~clk;

   noise_reg_if #(.TRIG_CYCLES(TrigCycles)) dut (
      .clk(clk), .reset(reset), .power_on(power_on), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
      .length(length), .start_vol(start_vol), .env_dir(env_dir), .env_period(env_period),
      .clock_shift(clock_shift), .width_mode(width_mode), .divisor(divisor),
      .length_en(length_en), .length_load(length_load), .trigger(trigger)
   );

   always @(negedge clk) if (rd_valid === 1'b1) rdValidSeen = 1'b1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [22:0] mkCfg(input logic [5:0] len, input logic [3:0] sv, input logic dir,
                                         input logic [2:0] per, input logic [3:0] cs, input logic wm,
                                         input logic [2:0] dv, input logic le);
      return {len, sv, dir, per, cs, wm, dv, le};
   endfunction

   function automatic logic [22:0] dutCfg();
      return {length, start_vol, env_dir, env_period, clock_shift, width_mode, divisor, length_en};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      power_on = v.power;
      wr_en    = v.wr;
      addr     = v.addr;
      wr_data  = v.data;
      rd_en    = 1'b0;
      sbQ.push_back('{cfg: v.cfg, ll: v.ll, trig: v.trig});
      tick();
      wr_en = 1'b0;
   endtask

   task automatic checkScoreboard(input int idx);
      if (sbQ.size() == 0) begin
         checkOutput($sformatf("sbEmpty%0d", idx), 32'd0, 32'd1);
      end else begin
         expRec = sbQ.pop_front();
         checkOutput($sformatf("cfg%0d", idx), 32'(dutCfg()), 32'(expRec.cfg));
         checkOutput($sformatf("lenLoad%0d", idx), 32'(length_load), 32'(expRec.ll));
         checkOutput($sformatf("trig%0d", idx), 32'(trigger), 32'(expRec.trig));
      end
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      addr    = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [1:0] a, input logic wr, input logic [7:0] d,
                            input logic [8:0] exp);
      rd_en   = 1'b1;
      wr_en   = wr;
      addr    = a;
      wr_data = d;
      rdQ.push_back(exp);
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      rdExp = rdQ.pop_front();
      checkOutput({name, "Valid"}, 32'(rd_valid), 32'(rdExp[8]));
      checkOutput({name, "Data"}, 32'(rd_data), 32'(rdExp[7:0]));
   endtask

   initial begin
      reset = 1'b1; power_on = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = 8'h00;

      vecs[0] = '{power: 1, wr: 1, addr: 2'd1, data: 8'hF3, cfg: mkCfg(6'd0, 4'd15, 1'b0, 3'd3, 4'd0, 1'b0, 3'd0, 1'b0), ll: 0, trig: 0};
      vecs[1] = '{power: 1, wr: 1, addr: 2'd2, data: 8'h5A, cfg: mkCfg(6'd0, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b0), ll: 0, trig: 0};
      vecs[2] = '{power: 1, wr: 1, addr: 2'd0, data: 8'hFF, cfg: mkCfg(6'd63, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b0), ll: 1, trig: 0};
      vecs[3] = '{power: 1, wr: 0, addr: 2'd0, data: 8'h00, cfg: mkCfg(6'd63, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b0), ll: 0, trig: 0};
      vecs[4] = '{power: 1, wr: 1, addr: 2'd0, data: 8'hC5, cfg: mkCfg(6'd5, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b0), ll: 1, trig: 0};
      vecs[5] = '{power: 1, wr: 1, addr: 2'd3, data: 8'h40, cfg: mkCfg(6'd5, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b1), ll: 0, trig: 0};
      vecs[6] = '{power: 1, wr: 1, addr: 2'd3, data: 8'h00, cfg: mkCfg(6'd5, 4'd15, 1'b0, 3'd3, 4'd5, 1'b1, 3'd2, 1'b0), ll: 0, trig: 0};
      vecs[7] = '{power: 0, wr: 1, addr: 2'd1, data: 8'h77, cfg: 23'd0, ll: 0, trig: 0};
      vecs[8] = '{power: 0, wr: 1, addr: 2'd0, data: 8'h3F, cfg: 23'd0, ll: 0, trig: 0};
      vecs[9] = '{power: 1, wr: 1, addr: 2'd2, data: 8'h81, cfg: mkCfg(6'd0, 4'd0, 1'b0, 3'd0, 4'd8, 1'b0, 3'd1, 1'b0), ll: 0, trig: 0};

      tick();
      tick();
      checkOutput("rstCfg", 32'(dutCfg()), 32'd0);
      checkOutput("rstLenLoad", 32'(length_load), 32'd0);
      checkOutput("rstTrig", 32'(trigger), 32'd0);
      checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
`ifdef NOISE_REG_READBACK_EN
      checkOutput("rstRdData", 32'(rd_data), 32'h00);
`else
      checkOutput("rstRdData", 32'(rd_data), 32'hFF);
`endif
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkScoreboard(i);
      end
      power_on = 1'b1;

      writeReg(2'd2, 8'h5A);
      checkOutput("nr43Cfg", 32'(dutCfg()), 32'(mkCfg(6'd0, 4'd0, 1'b0, 3'd0, 4'd5, 1'b1, 3'd2, 1'b0)));
`ifdef NOISE_REG_READBACK_EN
      readCheck("rdNr43", 2'd2, 1'b0, 8'h00, {1'b1, 8'h5A});
      tick();
      checkOutput("rdValidDrop", 32'(rd_valid), 32'd0);
      readCheck("rdNr41", 2'd0, 1'b0, 8'h00, {1'b1, 8'hFF});
      readCheck("rdDuringWr", 2'd1, 1'b1, 8'h33, {1'b1, 8'h00});
      checkOutput("rdDuringWrCfg", 32'({start_vol, env_dir, env_period}), 32'h33);
`else
      readCheck("rdOffNr43", 2'd2, 1'b0, 8'h00, {1'b0, 8'hFF});
      readCheck("rdOffNr42", 2'd1, 1'b1, 8'h33, {1'b0, 8'hFF});
`endif

      // Single trigger: strobe must stay high for exactly TRIG_CYCLES samples.
      hiCount = 0;
      writeReg(2'd3, 8'hC0);
      checkOutput("trigAlenEn", 32'(length_en), 32'd1);
      if (trigger) hiCount++;
      for (int i = 0; i < 20 && trigger; i++) begin
         tick();
         if (trigger) hiCount++;
      end
      checkOutput("trigAHigh", 32'(hiCount), 32'(TrigCycles));
`ifdef NOISE_REG_READBACK_EN
      readCheck("rdNr44On", 2'd3, 1'b0, 8'h00, {1'b1, 8'hFF});
`endif

      // Retrigger two cycles in: contiguous strobe of 2 + TRIG_CYCLES samples.
      hiCount = 0;
      for (int k = 0; k < 20; k++) begin
         wr_en   = (k == 0) || (k == 2);
         addr    = 2'd3;
         wr_data = (k == 0) ? 8'hC0 : 8'h80;
         tick();
         wr_en = 1'b0;
         if (trigger) hiCount++;
         else if (hiCount > 0) break;
      end
      checkOutput("trigBHigh", 32'(hiCount), 32'(TrigCycles + 2));
      checkOutput("trigBLenEn", 32'(length_en), 32'd0);
`ifdef NOISE_REG_READBACK_EN
      readCheck("rdNr44Off", 2'd3, 1'b0, 8'h00, {1'b1, 8'hBF});
`endif

      writeReg(2'd0, 8'hFF);
      checkOutput("nr41Length", 32'(length), 32'd63);
      checkOutput("nr41Pulse", 32'(length_load), 32'd1);
      tick();
      checkOutput("nr41PulseEnd", 32'(length_load), 32'd0);
      writeReg(2'd3, 8'hC0);
      checkOutput("pwrTrigOn", 32'(trigger), 32'd1);
      tick();
      power_on = 1'b0;
      tick();
      checkOutput("pwrOffTrig", 32'(trigger), 32'd0);
      checkOutput("pwrOffCfg", 32'(dutCfg()), 32'd0);
      writeReg(2'd0, 8'h2A);
      checkOutput("pwrOffLenLoad", 32'(length_load), 32'd0);
      checkOutput("pwrOffLength", 32'(length), 32'd0);
      writeReg(2'd3, 8'hC0);
      checkOutput("pwrOffNoTrig", 32'(trigger), 32'd0);
      checkOutput("pwrOffNoLenEn", 32'(length_en), 32'd0);

      power_on = 1'b1;
      writeReg(2'd1, 8'hF3);
      writeReg(2'd3, 8'hC0);
      tick();
      checkOutput("preRstTrig", 32'(trigger), 32'd1);
      reset   = 1'b1;
      wr_en   = 1'b1;
      addr    = 2'd2;
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      checkOutput("rstFireTrig", 32'(trigger), 32'd0);
      checkOutput("rstFireCfg", 32'(dutCfg()), 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("postRstTrig", 32'(trigger), 32'd0);

`ifndef NOISE_REG_READBACK_EN
      checkOutput("rdValidNever", 32'(rdValidSeen), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
